decode_stage_hs: RTL and testbench

- Parametrised RV32I/RV64I decode stage and ID/EX pipeline register with valid/ready handshake toward fetch and execute.
- Successor to the fixed keep/nop decode register. Adds:
  - load-use interlock;
  - writeback bypass on both the capture path and the hold path;
  - unsigned branch codes;
  - optional M-extension and SYSTEM/FENCE decode;
  - illegal-instruction flagging.
- Sits between the fetch pipe register and the execute stage.

---
 rtl/decode_stage_hs_if.sv | 63 ++++++
 rtl/decode_stage_hs.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_stage_hs.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_hs_if.sv
// decode_stage_hs_if
//   Bundles every non-clock signal of decode_stage_hs: the fetch-side
//   valid/ready handshake (flush, in_valid, in_ready, inst, pc, pcp4), the
//   register-file read ports (read_reg*, read_data*), the writeback bypass
//   (wb_en, wb_addr, wb_data) and the registered ID/EX bundle toward execute
//   (out_valid, out_ready and all *_o fields).
//   modport slave  : the decode stage itself.
//   modport master : the surrounding pipeline (fetch, register file, execute).
interface decode_stage_hs_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     inst;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pcp4;
   logic [4:0]      read_reg1;
   logic [4:0]      read_reg2;
   logic [XLEN-1:0] read_data1;
   logic [XLEN-1:0] read_data2;
   logic            wb_en;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] pcp4_o;
   logic [XLEN-1:0] imm_o;
   logic [XLEN-1:0] rs1_data_o;
   logic [XLEN-1:0] rs2_data_o;
   logic [4:0]      rs1_o;
   logic [4:0]      rs2_o;
   logic [4:0]      rd_o;
   logic            regwrite_o;
   logic [1:0]      memtoreg_o;
   logic [1:0]      memrw_o;
   logic [2:0]      membranch_o;
   logic [2:0]      alu_ctrl_o;
   logic [2:0]      alu_src_o;
   logic [3:0]      alu_fn_o;
   logic [6:0]      funct7_o;
   logic [31:0]     inst_o;
   logic            illegal_o;

   modport slave (
      input  flush, in_valid, inst, pc, pcp4, read_data1, read_data2,
             wb_en, wb_addr, wb_data, out_ready,
      output in_ready, read_reg1, read_reg2, out_valid, pc_o, pcp4_o, imm_o,
             rs1_data_o, rs2_data_o, rs1_o, rs2_o, rd_o, regwrite_o, memtoreg_o,
             memrw_o, membranch_o, alu_ctrl_o, alu_src_o, alu_fn_o, funct7_o,
             inst_o, illegal_o
   );

   modport master (
      output flush, in_valid, inst, pc, pcp4, read_data1, read_data2,
             wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, read_reg1, read_reg2, out_valid, pc_o, pcp4_o, imm_o,
             rs1_data_o, rs2_data_o, rs1_o, rs2_o, rd_o, regwrite_o, memtoreg_o,
             memrw_o, membranch_o, alu_ctrl_o, alu_src_o, alu_fn_o, funct7_o,
             inst_o, illegal_o
   );
endinterface

// File: rtl/decode_stage_hs.sv
// decode_stage_hs
//   RV32I/RV64I decode stage plus ID/EX pipeline register with a valid/ready
//   handshake on both sides, load-use interlock (one bubble), writeback
//   bypass on capture and while holding, optional M and SYSTEM/FENCE decode
//   and illegal-instruction flagging.
//   Ports: clk, rst (synchronous, active high) and bus (decode_stage_hs_if,
//   slave modport) carrying the fetch, register-file, writeback and execute
//   signals.
module decode_stage_hs #(
   parameter int XLEN   = 32,
   parameter bit EN_M   = 1'b1,
   parameter bit EN_SYS = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   decode_stage_hs_if.slave bus
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32= 7'b0011011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP32   = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

   // Image of the whole ID/EX register; valid doubles as out_valid.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc, pcp4, imm, rs1_data, rs2_data;
      logic [4:0]      rs1, rs2, rd;
      logic            regwrite;
      logic [1:0]      memtoreg, memrw;
      logic [2:0]      membranch, alu_ctrl, alu_src;
      logic [3:0]      alu_fn;
      logic [6:0]      funct7;
      logic [31:0]     inst;
      logic            illegal;
   } pipe_t;

   localparam pipe_t PIPE_ZERO = {$bits(pipe_t){1'b0}};

   // Writeback forwarding match; x0 is never forwarded.
   function automatic logic wb_hit(input logic en, input logic [4:0] waddr,
                                   input logic [4:0] raddr);
      return en && (waddr != 5'd0) && (waddr == raddr);
   endfunction

   state_t          state_q, state_d;
   pipe_t           out_q, out_d, dec_s;
   logic [31:0]     inst_s;
   logic [6:0]      opc_s;
   logic [2:0]      f3_s;
   logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
   logic            uses_rs1_s, uses_rs2_s, ill_s;
   logic            hazard_s, in_ready_s, capture_s;

   assign inst_s  = bus.inst;
   assign opc_s   = inst_s[6:0];
   assign f3_s    = inst_s[14:12];
   assign imm_i_s = XLEN'($signed(inst_s[31:20]));
   assign imm_s_s = XLEN'($signed({inst_s[31:25], inst_s[11:7]}));
   assign imm_b_s = XLEN'($signed({inst_s[31], inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0}));
   assign imm_u_s = XLEN'($signed({inst_s[31:12], 12'b0}));
   assign imm_j_s = XLEN'($signed({inst_s[31], inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0}));

   // Decode the presented instruction into the image the register would capture.
   always_comb begin
      dec_s          = PIPE_ZERO;
      uses_rs1_s     = 1'b0;
      uses_rs2_s     = 1'b0;
      ill_s          = 1'b0;
      dec_s.valid    = 1'b1;
      dec_s.pc       = bus.pc;
      dec_s.pcp4     = bus.pcp4;
      dec_s.rs1      = inst_s[19:15];
      dec_s.rs2      = inst_s[24:20];
      dec_s.rd       = inst_s[11:7];
      dec_s.funct7   = inst_s[31:25];
      dec_s.inst     = inst_s;
      dec_s.alu_fn   = {1'b0, f3_s};
      dec_s.rs1_data = wb_hit(bus.wb_en, bus.wb_addr, inst_s[19:15]) ? bus.wb_data : bus.read_data1;
      dec_s.rs2_data = wb_hit(bus.wb_en, bus.wb_addr, inst_s[24:20]) ? bus.wb_data : bus.read_data2;
      case (opc_s)
         OPC_LUI: begin
            dec_s.regwrite = 1'b1; dec_s.imm = imm_u_s;
            dec_s.alu_ctrl = 3'b010; dec_s.alu_src = 3'b010; dec_s.alu_fn = 4'b0000;
         end
         OPC_AUIPC: begin
            dec_s.regwrite = 1'b1; dec_s.imm = imm_u_s;
            dec_s.alu_src = 3'b110; dec_s.alu_fn = 4'b0000;
         end
         OPC_JAL: begin
            dec_s.regwrite = 1'b1; dec_s.imm = imm_j_s; dec_s.membranch = 3'b111;
            dec_s.memtoreg = 2'b10; dec_s.alu_ctrl = 3'b011; dec_s.alu_src = 3'b100;
            dec_s.alu_fn = 4'b0000;
         end
         OPC_JALR: begin
            dec_s.regwrite = 1'b1; dec_s.imm = imm_i_s; dec_s.membranch = 3'b111;
            dec_s.memtoreg = 2'b10; dec_s.alu_ctrl = 3'b011; dec_s.alu_src = 3'b010;
            dec_s.alu_fn = 4'b0001; uses_rs1_s = 1'b1;
         end
         OPC_BRANCH: begin
            dec_s.imm = imm_b_s; dec_s.alu_ctrl = 3'b001; dec_s.alu_src = 3'b011;
            uses_rs1_s = 1'b1; uses_rs2_s = 1'b1;
            case (f3_s)
               3'b000:  dec_s.membranch = 3'b001;
               3'b001:  dec_s.membranch = 3'b010;
               3'b100:  dec_s.membranch = 3'b011;
               3'b101:  dec_s.membranch = 3'b100;
               3'b110:  dec_s.membranch = 3'b101;
               3'b111:  dec_s.membranch = 3'b110;
               default: ill_s = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec_s.regwrite = 1'b1; dec_s.imm = imm_i_s; dec_s.memrw = 2'b10;
            dec_s.memtoreg = 2'b01; dec_s.alu_ctrl = 3'b100; dec_s.alu_src = 3'b010;
            uses_rs1_s = 1'b1;
         end
         OPC_STORE: begin
            dec_s.imm = imm_s_s; dec_s.memrw = 2'b01; dec_s.rd = 5'd0;
            dec_s.alu_ctrl = 3'b101; dec_s.alu_src = 3'b010;
            uses_rs1_s = 1'b1; uses_rs2_s = 1'b1;
         end
         OPC_OPIMM, OPC_OPIMM32: begin
            // The 32-bit word forms exist only on RV64.
            ill_s = (opc_s == OPC_OPIMM32) && (XLEN != 64);
            dec_s.regwrite = 1'b1; dec_s.imm = imm_i_s; dec_s.alu_src = 3'b010;
            uses_rs1_s = 1'b1;
            // Shift-immediates carry the arithmetic/logical select in inst[30].
            dec_s.alu_fn = (f3_s[1:0] == 2'b01) ? {inst_s[30], f3_s} : {1'b0, f3_s};
         end
         OPC_OP, OPC_OP32: begin
            dec_s.regwrite = 1'b1; dec_s.alu_src = 3'b011; dec_s.alu_fn = {inst_s[30], f3_s};
            uses_rs1_s = 1'b1; uses_rs2_s = 1'b1;
            dec_s.alu_ctrl = (inst_s[31:25] == 7'b0000001) ? 3'b110 : 3'b000;
            ill_s = ((opc_s == OPC_OP32) && (XLEN != 64)) ||
                    ((inst_s[31:25] == 7'b0000001) && !EN_M);
         end
         OPC_SYSTEM, OPC_FENCE: begin
            dec_s.imm = imm_i_s; dec_s.alu_ctrl = 3'b111;
            // Only CSR accesses write rd; ECALL/EBREAK and FENCE do not.
            dec_s.regwrite = (opc_s == OPC_SYSTEM) && (f3_s != 3'b000);
            uses_rs1_s = (opc_s == OPC_SYSTEM) && (f3_s[2] == 1'b0) && (f3_s != 3'b000);
            ill_s = !EN_SYS;
         end
         default: ill_s = 1'b1;
      endcase
      // Illegal words still issue so the trap is taken downstream, but with no side effects.
      dec_s.illegal   = ill_s;
      dec_s.regwrite  = dec_s.regwrite & ~ill_s;
      dec_s.memrw     = ill_s ? 2'b00 : dec_s.memrw;
      dec_s.membranch = ill_s ? 3'b000 : dec_s.membranch;
   end

   // A load in the output register whose rd feeds the incoming instruction must wait one cycle.
   assign hazard_s = (state_q == ST_RUN) && out_q.valid && (out_q.memrw == 2'b10) &&
                     (out_q.rd != 5'd0) && bus.in_valid &&
                     ((uses_rs1_s && (out_q.rd == inst_s[19:15])) ||
                      (uses_rs2_s && (out_q.rd == inst_s[24:20])));
   assign in_ready_s = bus.flush || ((!out_q.valid || bus.out_ready) && !hazard_s);
   assign capture_s  = bus.in_valid && in_ready_s && !bus.flush;

   // Interlock FSM next state: one bubble after execute takes the load.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (hazard_s && bus.out_ready && !bus.flush) begin
               state_d = ST_BUBBLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_BUBBLE: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase
   end

   // Output register next state: flush, capture, drain to bubble, or hold with bypass.
   always_comb begin
      out_d = out_q;
      if (bus.flush) begin
         out_d = PIPE_ZERO;
      end else if (capture_s) begin
         out_d = dec_s;
      end else if (out_q.valid && bus.out_ready) begin
         out_d = PIPE_ZERO;
      end else begin
         out_d.rs1_data = wb_hit(bus.wb_en, bus.wb_addr, out_q.rs1) ? bus.wb_data : out_q.rs1_data;
         out_d.rs2_data = wb_hit(bus.wb_en, bus.wb_addr, out_q.rs2) ? bus.wb_data : out_q.rs2_data;
      end
   end

   // State and ID/EX register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         out_q   <= PIPE_ZERO;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign bus.in_ready    = in_ready_s;
   assign bus.read_reg1   = inst_s[19:15];
   assign bus.read_reg2   = inst_s[24:20];
   assign bus.out_valid   = out_q.valid;
   assign bus.pc_o        = out_q.pc;
   assign bus.pcp4_o      = out_q.pcp4;
   assign bus.imm_o       = out_q.imm;
   assign bus.rs1_data_o  = out_q.rs1_data;
   assign bus.rs2_data_o  = out_q.rs2_data;
   assign bus.rs1_o       = out_q.rs1;
   assign bus.rs2_o       = out_q.rs2;
   assign bus.rd_o        = out_q.rd;
   assign bus.regwrite_o  = out_q.regwrite;
   assign bus.memtoreg_o  = out_q.memtoreg;
   assign bus.memrw_o     = out_q.memrw;
   assign bus.membranch_o = out_q.membranch;
   assign bus.alu_ctrl_o  = out_q.alu_ctrl;
   assign bus.alu_src_o   = out_q.alu_src;
   assign bus.alu_fn_o    = out_q.alu_fn;
   assign bus.funct7_o    = out_q.funct7;
   assign bus.inst_o      = out_q.inst;
   assign bus.illegal_o   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage_hs.sv
// tb_decode_stage_hs
//   Self-checking bench for decode_stage_hs: directed scenarios plus a
//   randomized decode sweep checked against an instruction-level model.
//   Two instances: dut (EN_M=1) and dut_nm (EN_M=0).
module tb_decode_stage_hs;
   localparam int XLEN = 32;

   typedef struct {
      logic        rw;
      logic [1:0]  mtr, mrw;
      logic [2:0]  mb, ctrl, src;
      logic [3:0]  fn;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic clk;
   logic rst;
   int   pass_cnt = 0;
   int   tot_cnt  = 0;

   decode_stage_hs_if #(.XLEN(XLEN)) bus ();
   decode_stage_hs_if #(.XLEN(XLEN)) bus_nm ();

   decode_stage_hs #(.XLEN(XLEN), .EN_M(1'b1), .EN_SYS(1'b1)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   decode_stage_hs #(.XLEN(XLEN), .EN_M(1'b0), .EN_SYS(1'b1)) dut_nm (
      .clk(clk), .rst(rst), .bus(bus_nm));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction-level reference: what each RISC-V instruction class must produce.
   function automatic exp_t model(input logic [31:0] i, input bit en_m);
      exp_t  e;
      int    v;
      int    f3;
      int    bmap [8];
      string k;
      bmap = '{1, 2, 0, 0, 3, 4, 5, 6};
      f3 = int'(i[14:12]);
      e.rw = 1'b0; e.mtr = 2'd0; e.mrw = 2'd0; e.mb = 3'd0; e.ctrl = 3'd0; e.src = 3'd0;
      e.fn = 4'(f3); e.imm = 32'd0; e.rd = i[11:7]; e.ill = 1'b0;
      k = "bad";
      if (i[1:0] == 2'b11) begin
         case (i[6:2])
            5'h0D: k = "lui";    5'h05: k = "auipc"; 5'h1B: k = "jal";
            5'h19: k = "jalr";   5'h18: k = "branch"; 5'h00: k = "load";
            5'h08: k = "store";  5'h04: k = "opimm";  5'h0C: k = "op";
            5'h1C: k = "system"; 5'h03: k = "fence";
            default: k = "bad";
         endcase
      end
      case (k)
         "lui":   begin e.rw = 1'b1; e.imm = i & 32'hFFFFF000; e.ctrl = 3'd2; e.src = 3'd2; e.fn = 4'd0; end
         "auipc": begin e.rw = 1'b1; e.imm = i & 32'hFFFFF000; e.src = 3'd6; e.fn = 4'd0; end
         "jal": begin
            v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            if (i[31]) v = v - (1 << 21);
            e.imm = 32'(v); e.rw = 1'b1; e.mb = 3'd7; e.mtr = 2'd2; e.ctrl = 3'd3; e.src = 3'd4; e.fn = 4'd0;
         end
         "branch": begin
            v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            if (i[31]) v = v - 8192;
            e.imm = 32'(v); e.ctrl = 3'd1; e.src = 3'd3; e.mb = 3'(bmap[f3]);
            e.ill = (f3 == 2) || (f3 == 3);
         end
         "store": begin
            v = int'(i[31:25]) * 32 + int'(i[11:7]);
            if (i[31]) v = v - 4096;
            e.imm = 32'(v); e.mrw = 2'd1; e.rd = 5'd0; e.ctrl = 3'd5; e.src = 3'd2;
         end
         "jalr", "load", "opimm", "system", "fence": begin
            v = int'(i[31:20]);
            if (i[31]) v = v - 4096;
            e.imm = 32'(v);
            if (k == "jalr")   begin e.rw = 1'b1; e.mb = 3'd7; e.mtr = 2'd2; e.ctrl = 3'd3; e.src = 3'd2; e.fn = 4'd1; end
            if (k == "load")   begin e.rw = 1'b1; e.mrw = 2'd2; e.mtr = 2'd1; e.ctrl = 3'd4; e.src = 3'd2; end
            if (k == "opimm")  begin e.rw = 1'b1; e.src = 3'd2; if (f3 == 1 || f3 == 5) e.fn = 4'(int'(i[30]) * 8 + f3); end
            if (k == "system") begin e.ctrl = 3'd7; e.rw = (f3 != 0); end
            if (k == "fence")  e.ctrl = 3'd7;
         end
         "op": begin
            e.rw = 1'b1; e.src = 3'd3; e.fn = 4'(int'(i[30]) * 8 + f3);
            if (i[31:25] == 7'd1) begin e.ctrl = 3'd6; e.ill = !en_m; end
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) begin e.rw = 1'b0; e.mrw = 2'd0; e.mb = 3'd0; end
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      logic [6:0]  ops [11];
      int          sel;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
      r   = $urandom;
      sel = $urandom_range(0, 12);
      if (sel < 11) r[6:0] = ops[sel];
      if (sel == 8) begin
         case ($urandom_range(0, 2))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: r[31:25] = 7'h01;
         endcase
      end
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.inst = 32'd0; bus.pc = 32'd0; bus.pcp4 = 32'd4;
      bus.read_data1 = 32'd0; bus.read_data2 = 32'd0; bus.wb_en = 1'b0; bus.wb_addr = 5'd0;
      bus.wb_data = 32'd0; bus.out_ready = 1'b1;
      bus_nm.flush = 1'b0; bus_nm.in_valid = 1'b0; bus_nm.inst = 32'd0; bus_nm.pc = 32'd0;
      bus_nm.pcp4 = 32'd4; bus_nm.read_data1 = 32'd0; bus_nm.read_data2 = 32'd0; bus_nm.wb_en = 1'b0;
      bus_nm.wb_addr = 5'd0; bus_nm.wb_data = 32'd0; bus_nm.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      idle(); rst = 1'b1; step(); step(); rst = 1'b0;
      bus.inst = 32'h00012303; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      step(); step();
      tot_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL reset_stall_valid got %b want 1", bus.out_valid); else pass_cnt++;
      rst = 1'b1; step(); rst = 1'b0; bus.in_valid = 1'b0; #1;
      tot_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else pass_cnt++;
      tot_cnt++; if ({bus.imm_o, bus.rd_o, bus.regwrite_o, bus.memrw_o, bus.memtoreg_o, bus.alu_ctrl_o, bus.inst_o} !== 77'd0)
         $display("FAIL reset_fields got %h want 0", {bus.imm_o, bus.rd_o, bus.regwrite_o, bus.memrw_o, bus.memtoreg_o, bus.alu_ctrl_o, bus.inst_o});
      else pass_cnt++;
      tot_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
   endtask

   task automatic test_addi();
      idle(); bus.inst = 32'hFFD08293; bus.read_data1 = 32'd10; bus.in_valid = 1'b1; #1;
      tot_cnt++; if (bus.read_reg1 !== 5'd1) $display("FAIL addi_read_reg1 got %0d want 1", bus.read_reg1); else pass_cnt++;
      step(); bus.in_valid = 1'b0;
      tot_cnt++; if (bus.imm_o !== 32'hFFFFFFFD) $display("FAIL addi_imm got %h want fffffffd", bus.imm_o); else pass_cnt++;
      tot_cnt++; if (bus.rd_o !== 5'd5) $display("FAIL addi_rd got %0d want 5", bus.rd_o); else pass_cnt++;
      tot_cnt++; if (bus.regwrite_o !== 1'b1) $display("FAIL addi_regwrite got %b want 1", bus.regwrite_o); else pass_cnt++;
      tot_cnt++; if (bus.alu_src_o !== 3'b010) $display("FAIL addi_src got %b want 010", bus.alu_src_o); else pass_cnt++;
      tot_cnt++; if (bus.alu_ctrl_o !== 3'b000) $display("FAIL addi_ctrl got %b want 000", bus.alu_ctrl_o); else pass_cnt++;
      tot_cnt++; if (bus.rs1_data_o !== 32'd10) $display("FAIL addi_rs1_data got %h want 0a", bus.rs1_data_o); else pass_cnt++;
      step();
   endtask

   task automatic test_load_use();
      idle(); bus.inst = 32'h00012303; bus.in_valid = 1'b1; step();
      bus.inst = 32'h001303B3; bus.read_data1 = 32'h1234; #1;
      tot_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL lu_stall_ready got %b want 0", bus.in_ready); else pass_cnt++;
      step();
      tot_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL lu_bubble_valid got %b want 0", bus.out_valid); else pass_cnt++;
      tot_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL lu_bubble_ready got %b want 1", bus.in_ready); else pass_cnt++;
      bus.wb_en = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h55;
      step(); bus.in_valid = 1'b0; bus.wb_en = 1'b0;
      tot_cnt++; if ({bus.out_valid, bus.inst_o, bus.rd_o} !== {1'b1, 32'h001303B3, 5'd7})
         $display("FAIL lu_issue got %b/%h/%0d want 1/001303b3/7", bus.out_valid, bus.inst_o, bus.rd_o);
      else pass_cnt++;
      tot_cnt++; if (bus.rs1_data_o !== 32'h55) $display("FAIL lu_bypass got %h want 55", bus.rs1_data_o); else pass_cnt++;
      step();
   endtask

   task automatic test_hold_bypass();
      idle(); bus.inst = 32'h00328233; bus.read_data1 = 32'h11; bus.read_data2 = 32'h22;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0; step();
      bus.in_valid = 1'b0; bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hAA; step();
      tot_cnt++; if (bus.rs2_data_o !== 32'hAA) $display("FAIL hold_rs2 got %h want aa", bus.rs2_data_o); else pass_cnt++;
      tot_cnt++; if ({bus.out_valid, bus.rs1_data_o, bus.inst_o, bus.rs2_o} !== {1'b1, 32'h11, 32'h00328233, 5'd3})
         $display("FAIL hold_other got %b/%h/%h/%0d want 1/11/00328233/3", bus.out_valid, bus.rs1_data_o, bus.inst_o, bus.rs2_o);
      else pass_cnt++;
      bus.wb_addr = 5'd0; bus.wb_data = 32'h77; step();
      tot_cnt++; if ({bus.rs1_data_o, bus.rs2_data_o} !== {32'h11, 32'hAA})
         $display("FAIL hold_x0 got %h/%h want 11/aa", bus.rs1_data_o, bus.rs2_data_o);
      else pass_cnt++;
      bus.wb_en = 1'b0; bus.out_ready = 1'b1; step();
      tot_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL hold_drain got %b want 0", bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_branch();
      logic [31:0] insts [3];
      logic [2:0]  mbs [3];
      logic        ills [3];
      insts = '{32'h0020E463, 32'h0020F463, 32'h0020A463};
      mbs   = '{3'b101, 3'b110, 3'b000};
      ills  = '{1'b0, 1'b0, 1'b1};
      for (int n = 0; n < 3; n++) begin
         idle(); bus.inst = insts[n]; bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
         tot_cnt++; if ({bus.membranch_o, bus.illegal_o} !== {mbs[n], ills[n]})
            $display("FAIL branch_%0d got mb=%b ill=%b want mb=%b ill=%b", n, bus.membranch_o, bus.illegal_o, mbs[n], ills[n]);
         else pass_cnt++;
         tot_cnt++; if ({bus.out_valid, bus.imm_o} !== {1'b1, 32'd8})
            $display("FAIL branch_imm_%0d got %b/%h want 1/8", n, bus.out_valid, bus.imm_o);
         else pass_cnt++;
         step();
      end
   endtask

   task automatic test_no_m_and_flush();
      idle(); bus.inst = 32'h023100B3; bus.in_valid = 1'b1; bus_nm.inst = 32'h023100B3; bus_nm.in_valid = 1'b1;
      step(); bus.in_valid = 1'b0; bus_nm.in_valid = 1'b0;
      tot_cnt++; if ({bus_nm.out_valid, bus_nm.illegal_o, bus_nm.regwrite_o} !== 3'b110)
         $display("FAIL nom_mul got v/ill/rw=%b%b%b want 110", bus_nm.out_valid, bus_nm.illegal_o, bus_nm.regwrite_o);
      else pass_cnt++;
      tot_cnt++; if ({bus.illegal_o, bus.regwrite_o, bus.alu_ctrl_o} !== {1'b0, 1'b1, 3'b110})
         $display("FAIL m_mul got ill/rw/ctrl=%b%b%b want 01110", bus.illegal_o, bus.regwrite_o, bus.alu_ctrl_o);
      else pass_cnt++;
      // Held mul plus a new addi, both killed by flush.
      bus.out_ready = 1'b0; bus.inst = 32'hFFD08293; bus.in_valid = 1'b1; bus.flush = 1'b1; #1;
      tot_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", bus.in_ready); else pass_cnt++;
      step(); bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      tot_cnt++; if ({bus.out_valid, bus.regwrite_o, bus.inst_o} !== 34'd0)
         $display("FAIL flush_out got %b/%b/%h want 0/0/0", bus.out_valid, bus.regwrite_o, bus.inst_o);
      else pass_cnt++;
      step();
      tot_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL flush_dropped got %b want 0", bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_random_decode();
      exp_t        e;
      logic [31:0] w, d1, d2, x1, x2, pcv;
      for (int n = 0; n < 60; n++) begin
         idle();
         w = rand_inst(); d1 = $urandom; d2 = $urandom; pcv = {$urandom, 2'b00} & 32'hFFFFFFFC;
         bus.inst = w; bus.in_valid = 1'b1; bus.read_data1 = d1; bus.read_data2 = d2;
         bus.pc = pcv; bus.pcp4 = pcv + 32'd4;
         bus.wb_en = 1'($urandom_range(0, 1)); bus.wb_addr = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
         x1 = (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == w[19:15]) ? bus.wb_data : d1;
         x2 = (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == w[24:20]) ? bus.wb_data : d2;
         e = model(w, 1'b1);
         step(); bus.in_valid = 1'b0; bus.wb_en = 1'b0;
         tot_cnt++;
         if ({bus.out_valid, bus.regwrite_o, bus.memtoreg_o, bus.memrw_o, bus.membranch_o, bus.alu_ctrl_o,
              bus.alu_src_o, bus.alu_fn_o, bus.illegal_o, bus.rd_o} !==
             {1'b1, e.rw, e.mtr, e.mrw, e.mb, e.ctrl, e.src, e.fn, e.ill, e.rd})
            $display("FAIL rand_ctrl inst=%h got %h want %h", w,
                     {bus.out_valid, bus.regwrite_o, bus.memtoreg_o, bus.memrw_o, bus.membranch_o, bus.alu_ctrl_o,
                      bus.alu_src_o, bus.alu_fn_o, bus.illegal_o, bus.rd_o},
                     {1'b1, e.rw, e.mtr, e.mrw, e.mb, e.ctrl, e.src, e.fn, e.ill, e.rd});
         else pass_cnt++;
         tot_cnt++; if (bus.imm_o !== e.imm) $display("FAIL rand_imm inst=%h got %h want %h", w, bus.imm_o, e.imm); else pass_cnt++;
         tot_cnt++;
         if ({bus.rs1_data_o, bus.rs2_data_o, bus.pc_o, bus.inst_o} !== {x1, x2, pcv, w})
            $display("FAIL rand_data inst=%h got %h want %h", w, {bus.rs1_data_o, bus.rs2_data_o, bus.pc_o, bus.inst_o},
                     {x1, x2, pcv, w});
         else pass_cnt++;
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_addi();
      test_load_use();
      test_hold_bypass();
      test_branch();
      test_no_m_and_flush();
      test_random_decode();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
